// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous input snapshot,
// per-digit dp/blank, leading-zero suppression and PWM brightness.
module sevenseg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int SLOT_CYCLES = 208_333,
  parameter int BRIGHT_W    = 4
) (
  input  logic                  clk_100MHz_i,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] val_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic                  lz_suppress_i,
  input  logic [BRIGHT_W-1:0]   bright_i,
  output logic [7:0]            HEX_o,
  output logic [N_DIGITS-1:0]   AN_o,
  output logic                  frame_o
);

  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [BRIGHT_W-1:0]   pwm_cnt;
  logic                  slot_end;
  logic                  frame_end;

  logic [4*N_DIGITS-1:0] val_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic [N_DIGITS-1:0]   blank_sh;
  logic                  lz_sh;
  logic [BRIGHT_W-1:0]   bright_sh;

  logic [3:0]            nib_p0;
  logic                  dp_p0;
  logic                  blank_p0;
  logic                  sup_p0;
  logic                  zero_above;
  logic                  lit_p0;
  logic [7:0]            hex_p0;
  logic [N_DIGITS-1:0]   an_p0;
  logic                  frame_p0;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Scan counters; pwm restarts with each slot so every digit gets identical duty.
  always_ff @(posedge clk_100MHz_i) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      pwm_cnt  <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
    end
  end

  // Shadow copy tracks the inputs during reset, then only at frame end to avoid tearing.
  always_ff @(posedge clk_100MHz_i) begin
    if (!rst_n || frame_end) begin
      val_sh    <= val_i;
      dp_sh     <= dp_i;
      blank_sh  <= blank_i;
      lz_sh     <= lz_suppress_i;
      bright_sh <= bright_i;
    end
  end

  // p0: select digit and decode segments/anodes from the current scan state
  always_comb begin
    nib_p0     = '0;
    dp_p0      = 1'b0;
    blank_p0   = 1'b0;
    sup_p0     = 1'b0;
    zero_above = 1'b1;
    for (int d = N_DIGITS - 1; d >= 0; d--) begin
      zero_above = zero_above && (val_sh[4*d +: 4] == 4'h0);
      if (idx == IDX_W'(d)) begin
        nib_p0   = val_sh[4*d +: 4];
        dp_p0    = dp_sh[d];
        blank_p0 = blank_sh[d];
        sup_p0   = lz_sh && zero_above && (d != 0);
      end
    end
    lit_p0 = (bright_sh == '1) || (pwm_cnt < bright_sh);
    an_p0  = '1;
    for (int d = 0; d < N_DIGITS; d++) begin
      an_p0[d] = !(lit_p0 && (idx == IDX_W'(d)));
    end
    hex_p0   = blank_p0 ? 8'hFF : {~dp_p0, (sup_p0 ? 7'h7F : glyph(nib_p0))};
    frame_p0 = (idx == '0) && (slot_cnt == '0);
  end

  // p1: pin registers, segments and anodes change on the same edge
  always_ff @(posedge clk_100MHz_i) begin
    if (!rst_n) begin
      HEX_o   <= 8'hFF;
      AN_o    <= '1;
      frame_o <= 1'b0;
    end else begin
      HEX_o   <= hex_p0;
      AN_o    <= an_p0;
      frame_o <= frame_p0;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scenario bench for sevenseg_scan_ctrl (4 digits, 4-cycle slots, 2-bit brightness).
module tb_sevenseg_scan_ctrl;

  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk_100MHz_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] val_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic        lz_suppress_i = 1'b0;
  logic [1:0]  bright_i = '0;
  logic [7:0]  HEX_o;
  logic [3:0]  AN_o;
  logic        frame_o;

  int n_checks = 0;
  int n_fail = 0;
  logic [12:0] exp_q[$];

  sevenseg_scan_ctrl #(.N_DIGITS(4), .SLOT_CYCLES(4), .BRIGHT_W(2)) dut (
    .clk_100MHz_i (clk_100MHz_i),
    .rst_n        (rst_n),
    .val_i        (val_i),
    .dp_i         (dp_i),
    .blank_i      (blank_i),
    .lz_suppress_i(lz_suppress_i),
    .bright_i     (bright_i),
    .HEX_o        (HEX_o),
    .AN_o         (AN_o),
    .frame_o      (frame_o)
  );

  always #5 clk_100MHz_i = ~clk_100MHz_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "time limit");
  end

  // Expected {frame, AN, HEX} after edge e (1 = first edge after release), from the spec timing.
  function automatic logic [12:0] model(int e, logic [15:0] v, logic [3:0] dp, logic [3:0] bl,
                                        logic lz, logic [1:0] br);
    int k, pos;
    logic [3:0] nib, an;
    logic [7:0] g, hx;
    logic sup, fr;
    k   = ((e - 1) / 4) % 4;
    pos = (e - 1) % 4;
    nib = v[4*k +: 4];
    sup = lz && (k >= 1) && ((v >> (4 * k)) == 16'h0);
    g   = GLYPH[nib];
    hx  = bl[k] ? 8'hFF : {~dp[k], (sup ? 7'h7F : g[6:0])};
    an  = 4'hF;
    if (br == 2'b11 || pos < int'(br)) an[k] = 1'b0;
    fr  = ((e - 1) % 16 == 0);
    return {fr, an, hx};
  endfunction

  task automatic tick();
    @(posedge clk_100MHz_i);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_100MHz_i);
    rst_n = 1'b0;
    repeat (3) @(posedge clk_100MHz_i);
    @(negedge clk_100MHz_i);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] got, exp;
    @(negedge clk_100MHz_i);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      val_i = 16'($urandom); dp_i = 4'($urandom); blank_i = 4'($urandom);
      lz_suppress_i = 1'($urandom); bright_i = 2'($urandom);
      exp_q.push_back({1'b0, 4'hF, 8'hFF});
      tick();
      got = {frame_o, AN_o, HEX_o};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_scan();
    logic [12:0] got, exp;
    val_i = 16'h12AF; dp_i = '0; blank_i = '0; lz_suppress_i = 1'b0; bright_i = 2'b11;
    apply_reset();
    for (int e = 1; e <= 36; e++) begin
      exp_q.push_back(model(e, 16'h12AF, 4'h0, 4'h0, 1'b0, 2'b11));
      tick();
      got = {frame_o, AN_o, HEX_o};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL scan edge %0d: got %h required %h", e, got, exp);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [12:0] got, exp;
    val_i = 16'h12AF; dp_i = '0; blank_i = '0; lz_suppress_i = 1'b0; bright_i = 2'b11;
    apply_reset();
    for (int e = 1; e <= 24; e++) begin
      if (e == 6) val_i = 16'h0005;
      exp_q.push_back(model(e, (e <= 16) ? 16'h12AF : 16'h0005, 4'h0, 4'h0, 1'b0, 2'b11));
      tick();
      got = {frame_o, AN_o, HEX_o};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL snapshot edge %0d: got %h required %h", e, got, exp);
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [12:0] got, exp;
    logic [15:0] v;
    logic [3:0]  dp;
    for (int ph = 0; ph < 2; ph++) begin
      v  = (ph == 0) ? 16'h0030 : 16'h0000;
      dp = (ph == 0) ? 4'b0000 : 4'b1000;
      val_i = v; dp_i = dp; blank_i = '0; lz_suppress_i = 1'b1; bright_i = 2'b11;
      apply_reset();
      for (int e = 1; e <= 16; e++) begin
        exp_q.push_back(model(e, v, dp, 4'h0, 1'b1, 2'b11));
        tick();
        got = {frame_o, AN_o, HEX_o};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL lzero phase %0d edge %0d: got %h required %h", ph, e, got, exp);
        end
      end
    end
  endtask

  task automatic test_dp_blank();
    logic [12:0] got, exp;
    val_i = 16'h8888; dp_i = 4'b0100; blank_i = 4'b0010; lz_suppress_i = 1'b0; bright_i = 2'b11;
    apply_reset();
    for (int e = 1; e <= 16; e++) begin
      exp_q.push_back(model(e, 16'h8888, 4'b0100, 4'b0010, 1'b0, 2'b11));
      tick();
      got = {frame_o, AN_o, HEX_o};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL dp_blank edge %0d: got %h required %h", e, got, exp);
      end
    end
  endtask

  task automatic test_brightness();
    logic [12:0] got, exp;
    logic [1:0]  br;
    for (int ph = 0; ph < 3; ph++) begin
      val_i = 16'h12AF; dp_i = '0; blank_i = '0; lz_suppress_i = 1'b0;
      bright_i = (ph == 0) ? 2'b01 : (ph == 1) ? 2'b00 : 2'b11;
      apply_reset();
      for (int e = 1; e <= 32; e++) begin
        if (ph == 2 && e == 6) bright_i = 2'b01;
        br = (ph == 0) ? 2'b01 : (ph == 1) ? 2'b00 : ((e <= 16) ? 2'b11 : 2'b01);
        exp_q.push_back(model(e, 16'h12AF, 4'h0, 4'h0, 1'b0, br));
        tick();
        got = {frame_o, AN_o, HEX_o};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL bright phase %0d edge %0d: got %h required %h", ph, e, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] got, exp;
    val_i = 16'h12AF; dp_i = '0; blank_i = '0; lz_suppress_i = 1'b0; bright_i = 2'b11;
    apply_reset();
    repeat (10) tick();
    rst_n = 1'b0;
    exp_q.push_back({1'b0, 4'hF, 8'hFF});
    tick();
    got = {frame_o, AN_o, HEX_o};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL midreset hold: got %h required %h", got, exp);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      exp_q.push_back(model(e, 16'h12AF, 4'h0, 4'h0, 1'b0, 2'b11));
      tick();
      got = {frame_o, AN_o, HEX_o};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL midreset restart edge %0d: got %h required %h", e, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_snapshot();
    test_leading_zeros();
    test_dp_blank();
    test_brightness();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
